// File: rtl/dcd_pkg.sv
// Shared constants, FSM state type and slot mapping for the decoder-side
// CKKS slot address generator.
package dcd_pkg;

  localparam int unsigned POLY_POWER  = 8192;
  localparam int unsigned POWER_WIDTH = $clog2(POLY_POWER);
  localparam int unsigned HALF        = POLY_POWER / 2;
  localparam int unsigned ADDR_WIDTH  = POWER_WIDTH - 1;
  localparam int unsigned POW_WIDTH   = POWER_WIDTH + 1;
  localparam int unsigned ROTATE_BASE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                  b_im;
    logic [ADDR_WIDTH-1:0] addr;
  } slot_t;

  // Fold the odd power orbit element into a half-buffer address plus real/imag select.
  function automatic slot_t slot_map(input logic [POW_WIDTH-1:0] pow);
    logic [POWER_WIDTH-1:0] t;
    slot_t                  s;
    t = POWER_WIDTH'((pow - POW_WIDTH'(1)) >> 1);
    if (t < POWER_WIDTH'(HALF)) begin
      s.b_im = 1'b1;
      s.addr = t[ADDR_WIDTH-1:0];
    end else begin
      s.b_im = 1'b0;
      s.addr = ADDR_WIDTH'(POWER_WIDTH'(POLY_POWER - 1) - t);
    end
    return s;
  endfunction

endpackage

// File: rtl/dcd_pow_step.sv
// Registered power-orbit step: pow <- pow*ROTATE_BASE mod 2N, with load-to-1.
// Exposes the value the register takes at the next edge so outputs can track it.
module dcd_pow_step #(
  parameter int unsigned POLY_POWER  = 8192,
  parameter int unsigned ROTATE_BASE = 3,
  localparam int unsigned PW         = $clog2(POLY_POWER) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  output logic [PW-1:0] pow_nxt_c
);

  logic [PW-1:0] pow;

  // Truncation to PW bits is the mod 2N reduction since 2N is a power of two.
  always_comb begin
    pow_nxt_c = pow;
    if (load) begin
      pow_nxt_c = PW'(1);
    end else if (en) begin
      pow_nxt_c = PW'(pow * PW'(ROTATE_BASE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pow <= PW'(1);
    end else begin
      pow <= pow_nxt_c;
    end
  end

endmodule

// File: rtl/dcd_addr_gen.sv
// Decoder slot address generator: walks k = 0..N/2-1 along the ROTATE_BASE^k orbit.
// Optional DCD_ADDR_BITREV_EN bit-reverses rd_addr for a bit-reversed FFT buffer.
module dcd_addr_gen
  import dcd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = dcd_pkg::ADDR_WIDTH,
  parameter int unsigned POLY_POWER  = dcd_pkg::POLY_POWER,
  parameter int unsigned ROTATE_BASE = dcd_pkg::ROTATE_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_vld,
  input  logic                  addr_rdy,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  b_im,
  output logic [ADDR_WIDTH-1:0] slot_idx,
  output logic                  last
);

  localparam int unsigned PW = $clog2(POLY_POWER) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(POLY_POWER / 2 - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    pow_load, pow_en, hs_c;
  logic [PW-1:0]           pow_nxt_c;
  slot_t                   map_c;
  logic [ADDR_WIDTH-1:0]   base_addr, map_addr;
  logic                    busy_nxt, done_nxt, vld_nxt, bim_nxt, last_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt, slot_nxt;

  dcd_pow_step #(
    .POLY_POWER  (POLY_POWER),
    .ROTATE_BASE (ROTATE_BASE)
  ) u_pow_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pow_load),
    .en        (pow_en),
    .pow_nxt_c (pow_nxt_c)
  );

  assign hs_c = addr_vld & addr_rdy;

  // Next state, counters and the registered output image of the next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pow_load  = 1'b0;
    pow_en    = 1'b0;
    done_nxt  = 1'b0;
    addr_nxt  = '0;
    bim_nxt   = 1'b0;
    slot_nxt  = '0;
    last_nxt  = 1'b0;

    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pow_load  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            pow_load  = 1'b1;
          end
        end
        RUN: begin
          if (hs_c) begin
            pow_en  = 1'b1;
            cnt_nxt = cnt + ADDR_WIDTH'(1);
            if (cnt == LAST_SLOT) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    map_c     = slot_map(pow_nxt_c);
    base_addr = ADDR_WIDTH'(map_c.addr);
`ifdef DCD_ADDR_BITREV_EN
    map_addr = '0;
    for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
      map_addr[i] = base_addr[ADDR_WIDTH-1-i];
    end
`else
    map_addr = base_addr;
`endif

    vld_nxt  = (state_nxt == RUN);
    busy_nxt = (state_nxt != IDLE);
    if (vld_nxt) begin
      addr_nxt = map_addr;
      bim_nxt  = map_c.b_im;
      slot_nxt = cnt_nxt;
      last_nxt = (cnt_nxt == LAST_SLOT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_vld <= 1'b0;
      rd_addr  <= '0;
      b_im     <= 1'b0;
      slot_idx <= '0;
      last     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      addr_vld <= vld_nxt;
      rd_addr  <= addr_nxt;
      b_im     <= bim_nxt;
      slot_idx <= slot_nxt;
      last     <= last_nxt;
    end
  end

endmodule
